// File: rtl/rtc_bus_ciclo.sv
// Bus-cycle generator for the RTC multiplexed AD bus: address phase, then a
// read or write data phase with timed strobes, finishing with a fin pulse.
module rtc_bus_ciclo #(
   parameter int unsigned T_PULSE = 10,
   parameter int unsigned T_GAP   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       activa,
   input  logic       w,
   input  logic [7:0] dir,
   input  logic [7:0] dato_esc,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       a_d,
   output logic [7:0] dato_leido,
   output logic       fin,
   output logic       ocupado
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_HOLD,
      DATA,
      DATA_HOLD,
      DONE,
      WAIT_REL
   } estado_t;

   // Counter is loaded with N-1 so that a phase of N cycles expires on its Nth edge
   localparam logic [7:0] CARGA_P = 8'(T_PULSE - 1);
   localparam logic [7:0] CARGA_G = 8'(T_GAP - 1);

   estado_t    estado, estado_sig;
   logic [7:0] cnt, cnt_sig;
   logic       w_l, w_l_sig;
   logic [7:0] dato_l, dato_l_sig;
   logic [7:0] ad_out_sig, dato_leido_sig;
   logic       ad_oe_sig, cs_n_sig, rd_n_sig, wr_n_sig, a_d_sig, fin_sig, ocupado_sig;
   logic       expira;

   assign expira = (cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado     <= IDLE;
         cnt        <= '0;
         w_l        <= 1'b0;
         dato_l     <= '0;
         ad_out     <= '0;
         ad_oe      <= 1'b0;
         cs_n       <= 1'b1;
         rd_n       <= 1'b1;
         wr_n       <= 1'b1;
         a_d        <= 1'b0;
         dato_leido <= '0;
         fin        <= 1'b0;
         ocupado    <= 1'b0;
      end else begin
         estado     <= estado_sig;
         cnt        <= cnt_sig;
         w_l        <= w_l_sig;
         dato_l     <= dato_l_sig;
         ad_out     <= ad_out_sig;
         ad_oe      <= ad_oe_sig;
         cs_n       <= cs_n_sig;
         rd_n       <= rd_n_sig;
         wr_n       <= wr_n_sig;
         a_d        <= a_d_sig;
         dato_leido <= dato_leido_sig;
         fin        <= fin_sig;
         ocupado    <= ocupado_sig;
      end
   end

   always_comb begin
      estado_sig     = estado;
      cnt_sig        = cnt;
      w_l_sig        = w_l;
      dato_l_sig     = dato_l;
      ad_out_sig     = ad_out;
      ad_oe_sig      = ad_oe;
      cs_n_sig       = cs_n;
      rd_n_sig       = rd_n;
      wr_n_sig       = wr_n;
      a_d_sig        = a_d;
      dato_leido_sig = dato_leido;
      fin_sig        = 1'b0;
      ocupado_sig    = ocupado;

      case (estado)
         IDLE: begin
            cs_n_sig  = 1'b1;
            rd_n_sig  = 1'b1;
            wr_n_sig  = 1'b1;
            ad_oe_sig = 1'b0;
            if (activa) begin
               w_l_sig     = w;
               dato_l_sig  = dato_esc;
               cs_n_sig    = 1'b0;
               wr_n_sig    = 1'b0;
               a_d_sig     = 1'b0;
               ad_oe_sig   = 1'b1;
               ad_out_sig  = dir;
               ocupado_sig = 1'b1;
               cnt_sig     = CARGA_P;
               estado_sig  = ADDR;
            end
         end
         ADDR: begin
            if (expira) begin
               cs_n_sig   = 1'b1;
               wr_n_sig   = 1'b1;
               cnt_sig    = CARGA_G;
               estado_sig = ADDR_HOLD;
            end else begin
               cnt_sig = cnt - 8'd1;
            end
         end
         ADDR_HOLD: begin
            if (expira) begin
               cs_n_sig = 1'b0;
               a_d_sig  = 1'b1;
               if (w_l) begin
                  wr_n_sig   = 1'b0;
                  ad_out_sig = dato_l;
                  ad_oe_sig  = 1'b1;
               end else begin
                  rd_n_sig  = 1'b0;
                  ad_oe_sig = 1'b0;
               end
               cnt_sig    = CARGA_P;
               estado_sig = DATA;
            end else begin
               cnt_sig = cnt - 8'd1;
            end
         end
         DATA: begin
            if (expira) begin
               cs_n_sig = 1'b1;
               rd_n_sig = 1'b1;
               wr_n_sig = 1'b1;
               if (!w_l) begin
                  dato_leido_sig = ad_in;
               end
               cnt_sig    = CARGA_G;
               estado_sig = DATA_HOLD;
            end else begin
               cnt_sig = cnt - 8'd1;
            end
         end
         DATA_HOLD: begin
            if (expira) begin
               fin_sig    = 1'b1;
               ad_oe_sig  = 1'b0;
               a_d_sig    = 1'b0;
               estado_sig = DONE;
            end else begin
               cnt_sig = cnt - 8'd1;
            end
         end
         DONE: begin
            estado_sig = WAIT_REL;
         end
         WAIT_REL: begin
            if (!activa) begin
               ocupado_sig = 1'b0;
               estado_sig  = IDLE;
            end
         end
         default: begin
            cs_n_sig    = 1'b1;
            rd_n_sig    = 1'b1;
            wr_n_sig    = 1'b1;
            ad_oe_sig   = 1'b0;
            a_d_sig     = 1'b0;
            ocupado_sig = 1'b0;
            cnt_sig     = '0;
            estado_sig  = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rtc_bus_ciclo.sv
// Bench for rtc_bus_ciclo: default and minimum-timing instances share stimulus
// and are compared each cycle against an interval-based timing model.
module tb_rtc_bus_ciclo;

   localparam int F_DEF = 2 * 10 + 2 * 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       activa, w;
   logic [7:0] dir, dato_esc, pad_val, pad_junk, dl_model;

   logic [7:0] ad_in_d, ad_out_d, dato_leido_d;
   logic       ad_oe_d, cs_n_d, rd_n_d, wr_n_d, a_d_d, fin_d, ocupado_d;
   logic [7:0] ad_in_m, ad_out_m, dato_leido_m;
   logic       ad_oe_m, cs_n_m, rd_n_m, wr_n_m, a_d_m, fin_m, ocupado_m;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic       cs_n, rd_n, wr_n, a_d, ad_oe, fin, ocupado;
      logic [7:0] ad_out, dl;
   } obs_t;

   always #5 clk = ~clk;

   // RTC pad: drives the register value only while the read strobe is low
   assign ad_in_d = rd_n_d ? pad_junk : pad_val;
   assign ad_in_m = rd_n_m ? pad_junk : pad_val;

   rtc_bus_ciclo u_def (
      .clk(clk), .reset(reset), .activa(activa), .w(w), .dir(dir),
      .dato_esc(dato_esc), .ad_in(ad_in_d), .ad_out(ad_out_d), .ad_oe(ad_oe_d),
      .cs_n(cs_n_d), .rd_n(rd_n_d), .wr_n(wr_n_d), .a_d(a_d_d),
      .dato_leido(dato_leido_d), .fin(fin_d), .ocupado(ocupado_d)
   );

   rtc_bus_ciclo #(.T_PULSE(1), .T_GAP(1)) u_min (
      .clk(clk), .reset(reset), .activa(activa), .w(w), .dir(dir),
      .dato_esc(dato_esc), .ad_in(ad_in_m), .ad_out(ad_out_m), .ad_oe(ad_oe_m),
      .cs_n(cs_n_m), .rd_n(rd_n_m), .wr_n(wr_n_m), .a_d(a_d_m),
      .dato_leido(dato_leido_m), .fin(fin_m), .ocupado(ocupado_m)
   );

   task automatic verificar(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs after edge E(k) of a transaction started at E0
   function automatic obs_t modelo(input int k, input int tp, input int tg, input logic wr,
                                   input logic [7:0] d, input logic [7:0] dt,
                                   input logic [7:0] rv, input logic [7:0] dl0, input int rel);
      obs_t m;
      int   f;
      f = 2 * tp + 2 * tg;
      m.cs_n = 1'b1; m.rd_n = 1'b1; m.wr_n = 1'b1; m.a_d = 1'b0;
      m.ad_oe = 1'b0; m.fin = 1'b0;
      m.ad_out = (wr && k >= tp + tg) ? dt : d;
      m.dl = (!wr && k >= 2 * tp + tg) ? rv : dl0;
      if (k < tp) begin
         m.cs_n = 1'b0; m.wr_n = 1'b0; m.ad_oe = 1'b1;
      end else if (k < tp + tg) begin
         m.ad_oe = 1'b1;
      end else if (k < 2 * tp + tg) begin
         m.cs_n = 1'b0; m.a_d = 1'b1;
         if (wr) begin
            m.wr_n = 1'b0; m.ad_oe = 1'b1;
         end else begin
            m.rd_n = 1'b0;
         end
      end else if (k < f) begin
         m.a_d = 1'b1; m.ad_oe = wr;
      end else if (k == f) begin
         m.fin = 1'b1;
      end
      m.ocupado = !(k >= f + 2 && k >= rel);
      return m;
   endfunction

   task automatic comparar(input string p, input obs_t o, input obs_t m);
      verificar({p, ".cs_n"},    8'(o.cs_n),    8'(m.cs_n));
      verificar({p, ".rd_n"},    8'(o.rd_n),    8'(m.rd_n));
      verificar({p, ".wr_n"},    8'(o.wr_n),    8'(m.wr_n));
      verificar({p, ".a_d"},     8'(o.a_d),     8'(m.a_d));
      verificar({p, ".ad_oe"},   8'(o.ad_oe),   8'(m.ad_oe));
      verificar({p, ".fin"},     8'(o.fin),     8'(m.fin));
      verificar({p, ".ocupado"}, 8'(o.ocupado), 8'(m.ocupado));
      verificar({p, ".ad_out"},  o.ad_out,      m.ad_out);
      verificar({p, ".dl"},      o.dl,          m.dl);
   endtask

   function automatic obs_t leer_def();
      return '{cs_n_d, rd_n_d, wr_n_d, a_d_d, ad_oe_d, fin_d, ocupado_d, ad_out_d, dato_leido_d};
   endfunction

   function automatic obs_t leer_min();
      return '{cs_n_m, rd_n_m, wr_n_m, a_d_m, ad_oe_m, fin_m, ocupado_m, ad_out_m, dato_leido_m};
   endfunction

   task automatic chk_reset(input string p);
      obs_t r;
      r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      comparar({p, "_def"}, leer_def(), r);
      comparar({p, "_min"}, leer_min(), r);
   endtask

   // One transaction; activa drops after edge E(drop); optional reset after E(rst_at)
   task automatic txn(input logic wr, input logic [7:0] d, input logic [7:0] dt,
                      input logic [7:0] rv, input int drop, input int rst_at);
      int rel;
      int kmax;
      rel = 1 << 30;
      kmax = ((F_DEF + 2 > drop + 1) ? F_DEF + 2 : drop + 1) + 1;
      w = wr; dir = d; dato_esc = dt; pad_val = rv; activa = 1'b1;
      for (int k = 0; k <= kmax; k++) begin
         @(negedge clk);
         comparar($sformatf("k%0d_def", k), leer_def(), modelo(k, 10, 5, wr, d, dt, rv, dl_model, rel));
         comparar($sformatf("k%0d_min", k), leer_min(), modelo(k, 1, 1, wr, d, dt, rv, dl_model, rel));
         if (k == rst_at) begin
            reset = 1'b1;
            activa = 1'b0;
            #1;
            chk_reset("rst_now");
            @(negedge clk);
            chk_reset("rst_hold");
            reset = 1'b0;
            dl_model = 8'h00;
            @(negedge clk);
            chk_reset("rst_after");
            return;
         end
         dir = 8'($urandom);
         dato_esc = 8'($urandom);
         w = 1'($urandom);
         pad_junk = 8'($urandom);
         if (k == drop) begin
            activa = 1'b0;
            rel = k + 1;
         end
      end
      if (!wr) dl_model = rv;
   endtask

   // Protocol invariants on both instances, sampled between edges
   logic       prev_ok = 1'b0;
   logic [1:0] p_ad, p_cs;
   always @(negedge clk) begin
      if (reset) begin
         prev_ok = 1'b0;
      end else begin
         verificar("excl_def", 8'(rd_n_d | wr_n_d), 8'd1);
         verificar("excl_min", 8'(rd_n_m | wr_n_m), 8'd1);
         verificar("oe_rd_def", 8'(ad_oe_d & ~rd_n_d), 8'd0);
         verificar("oe_rd_min", 8'(ad_oe_m & ~rd_n_m), 8'd0);
         if (prev_ok && a_d_d != p_ad[0]) verificar("ad_cs_def", 8'(p_cs[0]), 8'd1);
         if (prev_ok && a_d_m != p_ad[1]) verificar("ad_cs_min", 8'(p_cs[1]), 8'd1);
         p_ad = {a_d_m, a_d_d};
         p_cs = {cs_n_m, cs_n_d};
         prev_ok = 1'b1;
      end
   end

   initial begin
      reset = 1'b1; activa = 1'b0; w = 1'b0; dir = '0; dato_esc = '0;
      pad_val = '0; pad_junk = '0; dl_model = '0;
      repeat (3) @(negedge clk);
      chk_reset("por");
      reset = 1'b0;
      @(negedge clk);
      txn(1'b1, 8'h21, 8'h59, 8'h00, F_DEF, -1);
      txn(1'b0, 8'h22, 8'h3C, 8'hA7, F_DEF, -1);
      txn(1'b1, 8'h35, 8'h6E, 8'h00, F_DEF + 10, -1);
      txn(1'b1, 8'h44, 8'h99, 8'h00, F_DEF + 10, 18);
      txn(1'b0, 8'h23, 8'h00, 8'h5D, F_DEF, -1);
      for (int i = 0; i < 12; i++) begin
         txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, F_DEF + 6)), -1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
